pll_reset_sequencer: RTL

//  Sequences the core PLL: holds PLL reset for a fixed time after power-up, restart or lock loss.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  // Encodings are visible on the state output, so keep them fixed.
  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } state_e;

  // Largest of three cycle counts; sizes the shared counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds PLL in reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the downstream system reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RETRY_W       = 4
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               ready,
  output logic [1:0]         state,
  output logic               lock_lost,
  output logic               timeout,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned MaxCycles = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lock_s;
  logic              lock_lost_d;
  logic              retry_inc;
  logic              timeout_set;

  logic              pll_rst_q;
  logic              sys_reset_q;
  logic              ready_q;
  logic              lock_lost_q;
  logic              timeout_q;
  logic [RETRY_W-1:0] retry_cnt_q;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // Next-state, counter and event decode; restart_req overrides every transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = 1'b0;
    retry_inc   = 1'b0;
    timeout_set = 1'b0;

    if (restart_req) begin
      state_d = StPllRst;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == LockLast) begin
            state_d     = StPllRst;
            cnt_d       = '0;
            timeout_set = 1'b1;
            retry_inc   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStable: begin
          // A lock glitch restarts the lock wait but is not counted as a retry.
          if (!lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d     = StPllRst;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
            retry_inc   = 1'b1;
          end
        end
        default: begin
          state_d = StPllRst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and shared counter registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from next state so they move on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      pll_rst_q   <= (state_d == StPllRst);
      sys_reset_q <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
      lock_lost_q <= lock_lost_d;
      if (timeout_set) timeout_q <= 1'b1;
      if (retry_inc && (retry_cnt_q != '1)) retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign lock_lost = lock_lost_q;
  assign timeout   = timeout_q;
  assign retry_cnt = retry_cnt_q;

endmodule
